io_cfg_loader: RTL and testbench
================================

# io_cfg_loader

Serial configuration loader for a bank of I/O blocks. It hunts a bit-serial configuration stream for a sync byte and shifts in one frame of per-pin settings (2-bit tristate mode plus direct-or-registered input select). It checks the frame with a checksum and, on a match, atomically commits the settings to the configuration inputs of the I/O blocks downstream. It sits between the device configuration port and the I/O ring; the I/O blocks power up and remain in the high-Z, direct-input state until a valid frame is committed.

## Interface
- N_IOB, 36, number of I/O blocks configured by one frame (payload = 3*N_IOB bits)
- SYNC, 8'hA5, frame sync byte, shifted MSB first
- IOCLK  in  1  single clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- CFG_DIN  in  1  serial configuration data bit
- CFG_VALID  in  1  CFG_DIN is sampled on a rising IOCLK edge only when high
- CFG_ABORT  in  1  synchronous abort; returns to hunt and discards the shadow frame
- TSMUX_OUT  out  2*N_IOB  committed tristate mode, IOB i at bits [2i+1:2i] (00 = high-Z, 01 = drive when TS=1, 1x = always drive)
- DORREG_OUT  out  N_IOB  committed input select, IOB i at bit i (0 = direct pin, 1 = registered)
- BUSY  out  1  high in PAYLOAD and CHECK states
- CFG_DONE  out  1  one-cycle pulse when a frame commits
- CFG_ERR  out  1  one-cycle pulse on checksum mismatch

## Operation
- States: HUNT, PAYLOAD, CHECK. The state, counters and shift registers advance only on cycles with CFG_VALID=1.
- HUNT: 8-bit sync shifter, {sh[6:0],CFG_DIN}. When the value after the shift equals SYNC, go to PAYLOAD, clear the bit counter, the ones counter and the shadow. The sync bits themselves are not payload.
- PAYLOAD: accepts 3*N_IOB bits in order IOB0 TSMUX[1], TSMUX[0], DORREG, then IOB1, and so on. Each bit is written into its shadow position. An 8-bit ones counter increments modulo 256 for each 1 bit. After the last payload bit, go to CHECK.
- CHECK: shifts 8 checksum bits MSB first into a received-checksum register. On the 8th bit, compare with the ones counter (including any wrap past 255):
  - match: copy the shadow to TSMUX_OUT/DORREG_OUT and pulse CFG_DONE;
  - mismatch: outputs unchanged and pulse CFG_ERR.
  - Either way, return to HUNT with the sync shifter cleared to 0.
- Commit is atomic: all TSMUX_OUT and DORREG_OUT bits change on the same edge. They never change otherwise, except on reset.
- CFG_ABORT=1 in any state: next state HUNT, sync shifter cleared, no DONE/ERR, outputs unchanged. Abort has priority over CFG_VALID in the same cycle.
- Sync is matched only in HUNT. A SYNC pattern inside the payload or checksum is treated as data.
- Back-to-back frames are allowed. A new sync may start on the first valid bit after return to HUNT.

## Timing
- Reset (asynchronous, active-high) forces:
  - state HUNT; all shifters and counters 0;
  - TSMUX_OUT all 0 (high-Z), DORREG_OUT all 0;
  - BUSY=0, CFG_DONE=0, CFG_ERR=0.
- Reset mid-frame discards the shadow. The committed outputs also return to 0.
- BUSY rises on the edge that accepts the final sync bit. It falls on the edge that accepts the 8th checksum bit.
- CFG_DONE, CFG_ERR and the output commit are registered. They become visible in the cycle after the edge that accepts the final checksum bit, i.e. the same edge updates the outputs and asserts the pulse. The pulse lasts exactly one cycle, regardless of CFG_VALID.
- Minimum frame with CFG_VALID held high: 8 + 3*N_IOB + 8 cycles (124 for N_IOB=36).
- Bit counter width: clog2(3*N_IOB). Terminal count is 3*N_IOB-1. No wrap.

## Test plan
- Reset release, no stimulus -> TSMUX_OUT=0, DORREG_OUT=0, BUSY/DONE/ERR=0 for 50 cycles.
- N_IOB=2, continuous valid, frame A5, payload 011100, checksum 03 -> the cycle after bit 22: TSMUX_OUT=4'b1001, DORREG_OUT=2'b01, CFG_DONE pulses once, BUSY low.
- Same frame with checksum 04 -> CFG_ERR pulses once. Outputs keep their prior values.
- Same good frame with CFG_VALID deasserted for 3 cycles after every bit -> identical result. DONE is delayed accordingly, and BUSY stays high through the gaps.
- Garbage bits 1101_0010_1 preceding A5, then a valid frame -> commits correctly. A5 embedded inside the payload causes no resync.
- CFG_ABORT asserted during PAYLOAD, and separately RST pulsed during CHECK:
  - abort -> HUNT, no pulses, outputs retained;
  - reset -> outputs cleared to 0; the next full valid frame commits normally.

Source files
------------

// File: rtl/io_cfg_loader_if.sv
// Configuration-port bundle for io_cfg_loader: serial config stream in,
// committed per-pin I/O block settings and status pulses out.
interface io_cfg_loader_if #(
   parameter int N_IOB = 36
);
   logic                 CFG_DIN;
   logic                 CFG_VALID;
   logic                 CFG_ABORT;
   logic [2*N_IOB-1:0]   TSMUX_OUT;
   logic [N_IOB-1:0]     DORREG_OUT;
   logic                 BUSY;
   logic                 CFG_DONE;
   logic                 CFG_ERR;

   // Configuration port side: drives the serial stream, observes the I/O ring settings.
   modport master (
      output CFG_DIN, CFG_VALID, CFG_ABORT,
      input  TSMUX_OUT, DORREG_OUT, BUSY, CFG_DONE, CFG_ERR
   );

   // Loader side.
   modport slave (
      input  CFG_DIN, CFG_VALID, CFG_ABORT,
      output TSMUX_OUT, DORREG_OUT, BUSY, CFG_DONE, CFG_ERR
   );
endinterface

// File: rtl/io_cfg_loader.sv
// Serial configuration loader for a bank of I/O blocks. Hunts the bit stream
// for a sync byte, shifts one frame of per-pin settings into a shadow, checks
// a ones-count checksum and atomically commits the shadow to the I/O ring.
module io_cfg_loader #(
   parameter int          N_IOB = 36,
   parameter logic [7:0]  SYNC  = 8'hA5
) (
   input  logic          IOCLK,
   input  logic          RST,
   io_cfg_loader_if.slave bus
);

   localparam int                PL_BITS  = 3 * N_IOB;
   localparam int                CNT_W    = $clog2(PL_BITS);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PL_BITS - 1);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } state_t;

   state_t               state_q,   state_d;
   logic [7:0]           sync_q,    sync_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]           ones_q,    ones_d;
   logic [PL_BITS-1:0]   shadow_q,  shadow_d;
   logic [2:0]           chk_cnt_q, chk_cnt_d;
   logic [7:0]           rx_chk_q,  rx_chk_d;
   logic [2*N_IOB-1:0]   tsmux_q,   tsmux_d;
   logic [N_IOB-1:0]     dorreg_q,  dorreg_d;
   logic                 busy_q,    busy_d;
   logic                 done_q,    done_d;
   logic                 err_q,     err_d;

   logic [7:0]           sync_shift;
   logic [7:0]           chk_shift;
   logic [2*N_IOB-1:0]   commit_ts;
   logic [N_IOB-1:0]     commit_dr;

   assign sync_shift = {sync_q[6:0],   bus.CFG_DIN};
   assign chk_shift  = {rx_chk_q[6:0], bus.CFG_DIN};

   // Shadow is filled in stream order (TS[1], TS[0], DORREG per block); remap to output layout.
   always_comb begin
      commit_ts = '0;
      commit_dr = '0;
      for (int i = 0; i < N_IOB; i++) begin
         commit_ts[2*i+1] = shadow_q[3*i];
         commit_ts[2*i]   = shadow_q[3*i+1];
         commit_dr[i]     = shadow_q[3*i+2];
      end
   end

   // Next-state logic: everything advances only on valid bits, abort wins over valid.
   always_comb begin
      state_d   = state_q;
      sync_d    = sync_q;
      bit_cnt_d = bit_cnt_q;
      ones_d    = ones_q;
      shadow_d  = shadow_q;
      chk_cnt_d = chk_cnt_q;
      rx_chk_d  = rx_chk_q;
      tsmux_d   = tsmux_q;
      dorreg_d  = dorreg_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      if (bus.CFG_ABORT) begin
         state_d  = HUNT;
         sync_d   = '0;
         shadow_d = '0;
      end else if (bus.CFG_VALID) begin
         case (state_q)
            HUNT: begin
               sync_d = sync_shift;
               if (sync_shift == SYNC) begin
                  state_d   = PAYLOAD;
                  bit_cnt_d = '0;
                  ones_d    = '0;
                  shadow_d  = '0;
               end
            end
            PAYLOAD: begin
               shadow_d[bit_cnt_q] = bus.CFG_DIN;
               ones_d              = ones_q + {7'd0, bus.CFG_DIN};
               if (bit_cnt_q == LAST_CNT) begin
                  state_d   = CHECK;
                  chk_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            CHECK: begin
               rx_chk_d  = chk_shift;
               chk_cnt_d = chk_cnt_q + 3'd1;
               if (chk_cnt_q == 3'd7) begin
                  // The ones counter wraps modulo 256, so compare the raw byte.
                  if (chk_shift == ones_q) begin
                     tsmux_d  = commit_ts;
                     dorreg_d = commit_dr;
                     done_d   = 1'b1;
                  end else begin
                     err_d    = 1'b1;
                  end
                  state_d = HUNT;
                  sync_d  = '0;
               end
            end
            default: begin
               state_d = HUNT;
               sync_d  = '0;
            end
         endcase
      end

      busy_d = (state_d != HUNT);
   end

   // State and output registers; reset returns the I/O ring to high-Z, direct input.
   always_ff @(posedge IOCLK or posedge RST) begin
      if (RST) begin
         state_q   <= HUNT;
         sync_q    <= '0;
         bit_cnt_q <= '0;
         ones_q    <= '0;
         shadow_q  <= '0;
         chk_cnt_q <= '0;
         rx_chk_q  <= '0;
         tsmux_q   <= '0;
         dorreg_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         bit_cnt_q <= bit_cnt_d;
         ones_q    <= ones_d;
         shadow_q  <= shadow_d;
         chk_cnt_q <= chk_cnt_d;
         rx_chk_q  <= rx_chk_d;
         tsmux_q   <= tsmux_d;
         dorreg_q  <= dorreg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign bus.TSMUX_OUT  = tsmux_q;
   assign bus.DORREG_OUT = dorreg_q;
   assign bus.BUSY       = busy_q;
   assign bus.CFG_DONE   = done_q;
   assign bus.CFG_ERR    = err_q;

endmodule

// File: tb/tb_io_cfg_loader.sv
// Testbench for io_cfg_loader: a small loader (2 I/O blocks) for the directed
// and random frames, a large one (90 blocks) for checksum wrap and embedded sync.
module tb_io_cfg_loader;

   localparam int          NA   = 2;
   localparam int          NB   = 90;
   localparam logic [7:0]  SYNC = 8'hA5;

   typedef struct packed {
      logic r;
      logic a;
      logic v;
      logic d;
   } item_t;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   always #5 clk = ~clk;

   io_cfg_loader_if #(.N_IOB(NA)) ifa ();
   io_cfg_loader_if #(.N_IOB(NB)) ifb ();

   io_cfg_loader #(.N_IOB(NA), .SYNC(SYNC)) dut_a (.IOCLK(clk), .RST(rst_a), .bus(ifa));
   io_cfg_loader #(.N_IOB(NB), .SYNC(SYNC)) dut_b (.IOCLK(clk), .RST(rst_b), .bus(ifb));

   int checks = 0;
   int errors = 0;

   item_t q[$];

   // Reference model: frame-level view of the stream for each loader.
   int            mode     [2];   // 0 = hunting for sync, 1 = collecting a frame
   logic [7:0]    win      [2];
   logic [511:0]  fbuf     [2];
   int            fcnt     [2];
   logic [319:0]  exp_ts   [2];
   logic [319:0]  exp_dr   [2];
   logic          exp_busy [2];

   function automatic int nof(input int d);
      return (d == 0) ? NA : NB;
   endfunction

   function automatic logic [7:0] csum(input int n, input logic [319:0] p);
      int s = 0;
      for (int k = 0; k < 3*n; k++) s += p[k] ? 1 : 0;
      return 8'(s % 256);
   endfunction

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input int d);
      mode[d] = 0; win[d] = '0; fbuf[d] = '0; fcnt[d] = 0;
      exp_ts[d] = '0; exp_dr[d] = '0; exp_busy[d] = 1'b0;
   endtask

   task automatic model_item(input int d, input item_t it, output logic dn, output logic er);
      int n;
      int ones;
      logic [7:0] c;
      n  = nof(d);
      dn = 1'b0;
      er = 1'b0;
      if (it.r) begin
         model_reset(d);
      end else if (it.a) begin
         mode[d] = 0; win[d] = '0; fcnt[d] = 0; exp_busy[d] = 1'b0;
      end else if (it.v) begin
         if (mode[d] == 0) begin
            win[d] = {win[d][6:0], it.d};
            if (win[d] == SYNC) begin
               mode[d] = 1; fcnt[d] = 0; exp_busy[d] = 1'b1;
            end
         end else begin
            fbuf[d][fcnt[d]] = it.d;
            fcnt[d]++;
            if (fcnt[d] == 3*n + 8) begin
               ones = 0;
               for (int k = 0; k < 3*n; k++) ones += fbuf[d][k] ? 1 : 0;
               for (int k = 0; k < 8; k++) c[7-k] = fbuf[d][3*n+k];
               if ((ones % 256) == int'(c)) begin
                  dn = 1'b1;
                  for (int i = 0; i < n; i++) begin
                     exp_ts[d][2*i+1] = fbuf[d][3*i];
                     exp_ts[d][2*i]   = fbuf[d][3*i+1];
                     exp_dr[d][i]     = fbuf[d][3*i+2];
                  end
               end else begin
                  er = 1'b1;
               end
               mode[d] = 0; win[d] = '0; fcnt[d] = 0; exp_busy[d] = 1'b0;
            end
         end
      end
   endtask

   task automatic push_it(input logic r, input logic a, input logic v, input logic dd);
      item_t it;
      it.r = r; it.a = a; it.v = v; it.d = dd;
      q.push_back(it);
   endtask

   task automatic push_idle(input int k);
      for (int i = 0; i < k; i++) push_it(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
   endtask

   task automatic push_bit(input logic b, input int gap);
      push_it(1'b0, 1'b0, 1'b1, b);
      push_idle(gap);
   endtask

   task automatic push_byte(input logic [7:0] b, input int gap);
      for (int i = 7; i >= 0; i--) push_bit(b[i], gap);
   endtask

   task automatic push_payload(input int n, input logic [319:0] p, input int gap);
      for (int k = 0; k < 3*n; k++) push_bit(p[k], gap);
   endtask

   task automatic push_frame(input int n, input logic [319:0] p, input logic [7:0] c, input int gap);
      push_byte(SYNC, gap);
      push_payload(n, p, gap);
      push_byte(c, gap);
   endtask

   task automatic drive_idle();
      rst_a = 1'b0; rst_b = 1'b0;
      ifa.CFG_VALID = 1'b0; ifa.CFG_ABORT = 1'b0; ifa.CFG_DIN = 1'b0;
      ifb.CFG_VALID = 1'b0; ifb.CFG_ABORT = 1'b0; ifb.CFG_DIN = 1'b0;
   endtask

   // Plays the queued items into one loader, checking every cycle against the model.
   task automatic run(input int d, input string tag);
      item_t        it;
      logic         dn, er;
      logic [319:0] ots, odr;
      logic [2:0]   ofl;
      for (int i = 0; i < q.size(); i++) begin
         it = q[i];
         rst_a         = (d == 0) && it.r;
         rst_b         = (d == 1) && it.r;
         ifa.CFG_VALID = (d == 0) && it.v;
         ifa.CFG_ABORT = (d == 0) && it.a;
         ifa.CFG_DIN   = it.d;
         ifb.CFG_VALID = (d == 1) && it.v;
         ifb.CFG_ABORT = (d == 1) && it.a;
         ifb.CFG_DIN   = it.d;
         model_item(d, it, dn, er);
         @(posedge clk);
         #2;
         if (d == 0) begin
            ots = 320'(ifa.TSMUX_OUT); odr = 320'(ifa.DORREG_OUT);
            ofl = {ifa.BUSY, ifa.CFG_DONE, ifa.CFG_ERR};
         end else begin
            ots = 320'(ifb.TSMUX_OUT); odr = 320'(ifb.DORREG_OUT);
            ofl = {ifb.BUSY, ifb.CFG_DONE, ifb.CFG_ERR};
         end
         chk($sformatf("%s[%0d].busy_done_err", tag, i), 320'(ofl), 320'({exp_busy[d], dn, er}));
         chk($sformatf("%s[%0d].tsmux", tag, i), ots, exp_ts[d]);
         chk($sformatf("%s[%0d].dorreg", tag, i), odr, exp_dr[d]);
      end
      q.delete();
      drive_idle();
   endtask

   initial begin
      logic [319:0] p, pp, pr, pb, all_ts, all_dr;
      logic [7:0]   c;
      int           gap;

      drive_idle();
      rst_a = 1'b1;
      rst_b = 1'b1;
      model_reset(0);
      model_reset(1);

      // Reset state, checked while reset is held.
      repeat (3) @(posedge clk);
      #2;
      chk("rst_a.tsmux",  320'(ifa.TSMUX_OUT),  '0);
      chk("rst_a.dorreg", 320'(ifa.DORREG_OUT), '0);
      chk("rst_a.flags",  320'({ifa.BUSY, ifa.CFG_DONE, ifa.CFG_ERR}), '0);
      chk("rst_b.tsmux",  320'(ifb.TSMUX_OUT),  '0);
      chk("rst_b.dorreg", 320'(ifb.DORREG_OUT), '0);
      chk("rst_b.flags",  320'({ifb.BUSY, ifb.CFG_DONE, ifb.CFG_ERR}), '0);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // 50 cycles with no valid data: everything stays at reset values.
      push_idle(50);
      run(0, "idle");

      // Directed good frame: payload 011100, checksum 03.
      p = '0; p[5:0] = 6'b001110;
      push_frame(NA, p, 8'h03, 0);
      run(0, "good");
      chk("good.tsmux",  320'(ifa.TSMUX_OUT),  320'(4'b1001));
      chk("good.dorreg", 320'(ifa.DORREG_OUT), 320'(2'b01));
      chk("good.flags",  320'({ifa.BUSY, ifa.CFG_DONE, ifa.CFG_ERR}), 320'(3'b010));
      push_idle(2);
      run(0, "good_tail");

      // Wrong checksum: error pulse, outputs retained.
      push_frame(NA, p, 8'h04, 0);
      run(0, "bad");
      chk("bad.flags", 320'({ifa.BUSY, ifa.CFG_DONE, ifa.CFG_ERR}), 320'(3'b001));
      chk("bad.tsmux", 320'(ifa.TSMUX_OUT), 320'(4'b1001));
      push_idle(2);
      run(0, "bad_tail");

      // A different frame, then the directed frame with 3-cycle gaps after every bit.
      pp = '0; pp[5:0] = 6'b110001;
      push_frame(NA, pp, csum(NA, pp), 1);
      push_frame(NA, p, 8'h03, 3);
      run(0, "gap");
      chk("gap.tsmux",  320'(ifa.TSMUX_OUT),  320'(4'b1001));
      chk("gap.dorreg", 320'(ifa.DORREG_OUT), 320'(2'b01));

      // Garbage bits 1101_0010_1 ahead of frames, then a clean frame.
      for (int i = 8; i >= 0; i--) push_bit(1'((9'b110100101 >> i) & 9'd1), 0);
      push_frame(NA, p, 8'h03, 0);
      push_frame(NA, pp, 8'h03, 0);
      push_idle(1);
      run(0, "garbage");
      chk("garbage.tsmux",  320'(ifa.TSMUX_OUT),  320'(4'b0110));
      chk("garbage.dorreg", 320'(ifa.DORREG_OUT), 320'(2'b10));

      // Abort during payload (with valid high in the same cycle), then recovery.
      push_byte(SYNC, 0);
      push_bit(1'b1, 0); push_bit(1'b0, 0); push_bit(1'b1, 0);
      push_it(1'b0, 1'b1, 1'b1, 1'b1);
      push_idle(3);
      run(0, "abort");
      chk("abort.tsmux", 320'(ifa.TSMUX_OUT), 320'(4'b0110));
      chk("abort.flags", 320'({ifa.BUSY, ifa.CFG_DONE, ifa.CFG_ERR}), '0);
      push_frame(NA, p, 8'h03, 0);
      run(0, "abort_rec");
      chk("abort_rec.tsmux", 320'(ifa.TSMUX_OUT), 320'(4'b1001));

      // Reset pulsed during the checksum; the following frame commits normally.
      push_byte(SYNC, 0);
      push_payload(NA, pp, 0);
      push_bit(1'b0, 0); push_bit(1'b0, 0); push_bit(1'b0, 0); push_bit(1'b0, 0);
      push_it(1'b1, 1'b0, 1'b0, 1'b0);
      run(0, "rst_mid");
      chk("rst_mid.tsmux", 320'(ifa.TSMUX_OUT), '0);
      push_frame(NA, pp, 8'h03, 0);
      run(0, "rst_rec");
      chk("rst_rec.tsmux",  320'(ifa.TSMUX_OUT),  320'(4'b0110));
      chk("rst_rec.dorreg", 320'(ifa.DORREG_OUT), 320'(2'b10));

      // Randomized frames with garbage, gaps, bad checksums and stray aborts.
      for (int r = 0; r < 16; r++) begin
         pr = '0;
         for (int k = 0; k < 3*NA; k++) pr[k] = 1'($urandom_range(0, 1));
         gap = $urandom_range(0, 2);
         for (int g = $urandom_range(0, 5); g > 0; g--) push_bit(1'($urandom_range(0, 1)), 0);
         c = csum(NA, pr);
         if ($urandom_range(0, 3) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
         push_frame(NA, pr, c, gap);
         if ($urandom_range(0, 4) == 0)
            push_it(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         push_idle($urandom_range(0, 2));
      end
      run(0, "rand");

      // Large bank: ones count 270 wraps to 14.
      pb = '0;
      for (int k = 0; k < 3*NB; k++) pb[k] = 1'b1;
      push_frame(NB, pb, 8'd14, 0);
      run(1, "wrap");
      all_ts = '0; all_dr = '0;
      for (int i = 0; i < 2*NB; i++) all_ts[i] = 1'b1;
      for (int i = 0; i < NB; i++) all_dr[i] = 1'b1;
      chk("wrap.tsmux",  320'(ifb.TSMUX_OUT),  all_ts);
      chk("wrap.dorreg", 320'(ifb.DORREG_OUT), all_dr);
      chk("wrap.flags",  320'({ifb.BUSY, ifb.CFG_DONE, ifb.CFG_ERR}), 320'(3'b010));

      // Saturating instead of wrapping would give FF: must be rejected.
      push_frame(NB, pb, 8'hFF, 0);
      run(1, "nowrap");
      chk("nowrap.flags", 320'({ifb.BUSY, ifb.CFG_DONE, ifb.CFG_ERR}), 320'(3'b001));

      // Sync pattern embedded in the payload is plain data.
      pr = '0;
      for (int k = 0; k < 3*NB; k++) pr[k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) pr[40+k] = SYNC[7-k];
      push_frame(NB, pr, csum(NB, pr), 0);
      push_idle(1);
      run(1, "embed");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
